// File: rtl/rlink_cext_uart_pkg.sv
// Shared types for the rlink C-side <-> 8N1 UART bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rlink_cext_uart_pkg;

  // start + 8 data + stop
  localparam int unsigned BITS_PER_FRAME = 10;

  // index of the last data bit inside a frame (bit counter wraps after it)
  localparam logic [2:0] LAST_DATA_IDX = 3'(BITS_PER_FRAME - 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_t;

endpackage

// File: rtl/rlink_cext_uart_if.sv
// Byte-side interface between the C-side rlink stream and the UART bridge.
// Latency: n/a (wiring only).
// Backpressure: rx_hold=1 tells the master to keep rx_data/rx_val stable.
interface rlink_cext_uart_if;

  logic [7:0] rx_data;
  logic       rx_val;
  logic       rx_hold;
  logic [7:0] tx_data;
  logic       tx_ena;
  logic       rx_err;

  // bridge side
  modport slave (
    input  rx_data,
    input  rx_val,
    output rx_hold,
    output tx_data,
    output tx_ena,
    output rx_err
  );

  // C side
  modport master (
    output rx_data,
    output rx_val,
    input  rx_hold,
    input  tx_data,
    input  tx_ena,
    input  rx_err
  );

endinterface

// File: rtl/rlink_cext_uart_rx.sv
// Deserializer: 8N1 line from the DUT into tx_data/tx_ena byte strobes.
// Latency: tx_ena 2+CDIV/2+9*CDIV+1 clocks after the first edge sampling rxd=0.
// Backpressure: none; the C side must take every tx_ena strobe.
module rlink_cext_uart_rx
  import rlink_cext_uart_pkg::*;
#(
  parameter int CDIV    = 16,
  parameter int CDWIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rxd,
  output logic [7:0] o_tx_data,
  output logic       o_tx_ena,
  output logic       o_rx_err
);

  localparam logic [CDWIDTH-1:0] CNT_BIT  = CDWIDTH'(CDIV - 1);
  localparam logic [CDWIDTH-1:0] CNT_HALF = CDWIDTH'(CDIV / 2);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;
  rx_state_t          r_state;
  rx_state_t          w_state_nxt;
  logic [CDWIDTH-1:0] r_cnt;
  logic [CDWIDTH-1:0] w_cnt_nxt;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic [7:0]         r_tx_data;
  logic [7:0]         w_tx_data_nxt;
  logic               r_tx_ena;
  logic               w_tx_ena_nxt;
  logic               r_rx_err;
  logic               w_rx_err_nxt;
  logic               w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection;
  // all reset to the idle-high line level so reset never looks like a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Next-state and datapath for the receive FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_tx_data_nxt = r_tx_data;
    w_tx_ena_nxt  = 1'b0;
    w_rx_err_nxt  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (r_prev && !r_sync2) begin
          w_state_nxt = R_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end
      R_START: begin
        if (w_cnt_zero) begin
          if (r_sync2) begin
            // line went back high before mid start bit: treat as a glitch
            w_state_nxt = R_IDLE;
          end else begin
            w_state_nxt = R_DATA;
            w_cnt_nxt   = CNT_BIT;
            w_idx_nxt   = 3'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CDWIDTH'(1);
        end
      end
      R_DATA: begin
        if (w_cnt_zero) begin
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          w_cnt_nxt   = CNT_BIT;
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == LAST_DATA_IDX) begin
            w_state_nxt = R_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt - CDWIDTH'(1);
        end
      end
      R_STOP: begin
        if (w_cnt_zero) begin
          if (r_sync2) begin
            w_tx_data_nxt = r_shift;
            w_tx_ena_nxt  = 1'b1;
            w_state_nxt   = R_IDLE;
          end else begin
            // missing stop bit: drop the byte and wait out the break
            w_rx_err_nxt = 1'b1;
            w_state_nxt  = R_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt - CDWIDTH'(1);
        end
      end
      R_BREAK: begin
        if (r_sync2) begin
          w_state_nxt = R_IDLE;
        end
      end
      default: begin
        w_state_nxt = R_IDLE;
      end
    endcase
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
      r_tx_data <= 8'h00;
      r_tx_ena  <= 1'b0;
      r_rx_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_ena  <= w_tx_ena_nxt;
      r_rx_err  <= w_rx_err_nxt;
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_tx_ena  = r_tx_ena;
  assign o_rx_err  = r_rx_err;

endmodule

// File: rtl/rlink_cext_uart_bridge.sv
// Bridge between the rlink C-side byte stream and a DUT's 8N1 UART pins.
// Latency: txd start bit on the clock after accept; frame = 10*CDIV clocks.
// Backpressure: rx_hold=1 whenever the serializer is not idle; bytes held upstream.
module rlink_cext_uart_bridge
  import rlink_cext_uart_pkg::*;
#(
  parameter int CDIV    = 16,
  parameter int CDWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  rlink_cext_uart_if.slave  bus,
  output logic              txd,
  input  logic              rxd
);

  localparam logic [CDWIDTH-1:0] CNT_BIT = CDWIDTH'(CDIV - 1);

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [CDWIDTH-1:0] r_cnt;
  logic [CDWIDTH-1:0] w_cnt_nxt;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               r_txd;
  logic               w_txd_nxt;
  logic               r_hold;
  logic               w_hold_nxt;
  logic               w_accept;
  logic               w_cnt_zero;
  logic [7:0]         w_tx_data;
  logic               w_tx_ena;
  logic               w_rx_err;

  // r_hold is only low in S_IDLE (and never in the first cycle after reset)
  assign w_accept   = bus.rx_val && !r_hold;
  assign w_cnt_zero = (r_cnt == '0);

  // Next-state and datapath for the transmit FSM; txd and rx_hold are
  // derived from the next state so both outputs come straight from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_BIT;
          w_shift_nxt = bus.rx_data;
        end
      end
      S_START: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = CNT_BIT;
          w_idx_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - CDWIDTH'(1);
        end
      end
      S_DATA: begin
        if (w_cnt_zero) begin
          w_cnt_nxt   = CNT_BIT;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == LAST_DATA_IDX) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt - CDWIDTH'(1);
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CDWIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase

    w_hold_nxt = (w_state_nxt != S_IDLE);
  end

  // Transmit FSM state, shifter and registered line/hold outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_txd   <= 1'b1;
      r_hold  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign txd         = r_txd;
  assign bus.rx_hold = r_hold;

  rlink_cext_uart_rx #(
    .CDIV    (CDIV),
    .CDWIDTH (CDWIDTH)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_rxd     (rxd),
    .o_tx_data (w_tx_data),
    .o_tx_ena  (w_tx_ena),
    .o_rx_err  (w_rx_err)
  );

  assign bus.tx_data = w_tx_data;
  assign bus.tx_ena  = w_tx_ena;
  assign bus.rx_err  = w_rx_err;

endmodule

// File: doc/rlink_cext_uart_bridge.md
# rlink_cext_uart_bridge

Serial-line bridge between the rlink byte stream of the C-side simulation interface and a DUT's 8N1 UART pins. It serializes each byte delivered by the C side onto `txd`, which drives the DUT's serial receive input. It deserializes the DUT's serial transmit output on `rxd` into `tx_data`/`tx_ena` byte strobes for the C side. It sits between the DPI byte interface and the DUT in `tbcore_rlink` benches whose DUT exposes only a serial port.

## Interface
- `CDIV`, default 16: clocks per bit, must be even and at least 4.
- `CDWIDTH`, default 8: width of the bit-period counters; 2**CDWIDTH must be at least CDIV.

- `clk` in, 1: clock, all logic on the rising edge.
- `reset_n` in, 1: reset, asynchronous and active-low.
- `rx_data` in, 8: byte from the C side. Only bits [7:0] are used.
- `rx_val` in, 1: `rx_data` is valid.
- `rx_hold` out, 1: the bridge is busy. While it is 1, upstream keeps the current byte.
- `txd` out, 1: serial line to the DUT's receive pin. Idles high.
- `rxd` in, 1: serial line from the DUT's transmit pin. Asynchronous to `clk`.
- `tx_data` out, 8: deserialized byte for the C side.
- `tx_ena` out, 1: one-cycle strobe marking `tx_data` valid.
- `rx_err` out, 1: one-cycle strobe on a framing error.

## Operation
- **Byte accept:** a byte is accepted on a rising edge where `rx_val`=1 and `rx_hold`=0. The bridge latches `rx_data[7:0]` at that edge.
- **Serializer FSM** (states S_IDLE, S_START, S_DATA, S_STOP):
  - S_IDLE to S_START on accept.
  - S_START drives `txd`=0 for CDIV clocks.
  - S_DATA shifts out 8 bits, LSB first, each for CDIV clocks.
  - S_STOP drives `txd`=1 for CDIV clocks, then returns to S_IDLE.
- **`rx_hold` register:** registered. Its next value is 1 whenever the next state is not S_IDLE. Upstream therefore sees `rx_hold`=0 only in S_IDLE.
- **Deserializer input:** `rxd` passes through a 2-flop synchronizer, reset to 1.
- **Deserializer FSM** (states R_IDLE, R_START, R_DATA, R_STOP, R_BREAK):
  - R_IDLE to R_START on a synchronized 1-to-0 transition.
  - R_START waits CDIV/2 clocks, then samples. A sample of 1 is a false start and returns to R_IDLE with no strobe. A sample of 0 moves to R_DATA.
  - R_DATA takes 8 samples at CDIV-clock spacing, LSB first.
  - R_STOP samples CDIV clocks after the last data sample. A 1 strobes `tx_ena` with the byte and returns to R_IDLE. A 0 strobes `rx_err`, discards the byte and goes to R_BREAK.
  - R_BREAK waits for the synchronized line to be 1, then goes to R_IDLE.
- **Independence:** the two directions are fully independent. Simultaneous accept and `tx_ena` need no arbitration.
- **Counters:** bit counters count down from CDIV-1 to 0, CDWIDTH bits wide. The bit index is a 3-bit counter that wraps from 7 to 0 into the stop state.

## Timing
- **Reset values:** `txd`=1, `rx_hold`=1, `tx_ena`=0, `rx_err`=0, `tx_data`=0x00. Both FSMs are idle and the synchronizer flops are 1.
- **First accept after reset:** `rx_hold` drops to 0 on the first edge after `reset_n` deasserts, so the earliest accept is on the second edge.
- **Serializer latency:** the `txd` start bit begins on the clock after the accept edge. A frame is exactly 10*CDIV clocks. Back-to-back bytes take 10*CDIV+1 clocks each, because of one S_IDLE cycle.
- **Deserializer latency:** `tx_ena` rises 2+CDIV/2+9*CDIV+1 clocks after the first edge at which `rxd`=0 is sampled. `tx_data` holds its value until the next strobe.
- **Reset mid-frame:**
  - `txd` returns to 1 immediately, because reset is asynchronous.
  - The partial byte in each direction is discarded.
  - No `tx_ena` or `rx_err` is generated.
  - The upstream byte held under `rx_hold` is consumed at the first accept after reset.
- **`rx_val` during `rx_hold`=1:** ignored. `rx_data` changes while held are not sampled.

## Structure
- **Package `rlink_cext_uart_pkg`:** serializer and deserializer state enums, plus the constant for the bits-per-frame count (10).
- **Sub-module `rlink_cext_uart_rx`:** the deserializer (synchronizer, FSM, `tx_data`/`tx_ena`/`rx_err`), instantiated once.
- **Top level:** the serializer and `rx_hold` logic stay in the top level.

## Test plan
All scenarios use CDIV=16.
- **Single byte out:** `rx_val`=1 with `rx_data`=0xA5 -> `txd` shows a 0 start bit, then 1,0,1,0,0,1,0,1, then a stop bit, each bit 16 clocks. `rx_hold`=1 for 160 clocks.
- **Back-to-back out:** 0x00, 0xFF, 0x55 held continuously valid -> three frames at 161-clock spacing, each byte accepted exactly once.
- **Loopback:** `txd` tied to `rxd`, send 0x3C -> `tx_ena` pulses once with `tx_data`=0x3C, 2+8+144+1 clocks after the start bit appears.
- **Framing and glitch:**
  - Drive `rxd` low for 180 clocks -> one `rx_err` pulse, no `tx_ena`, no new frame until `rxd` returns to 1.
  - A 4-clock low glitch -> no strobe.
- **Reset mid-frame:** pull `reset_n` low during data bit 3 -> `txd`=1 at once and `rx_hold`=1. After release, the re-presented byte is sent as a complete frame.
- **Full duplex:** an outbound frame and an inbound 0x81 overlap -> both complete correctly and `tx_ena` pulses once.
